shift_seq_ctrl: RTL and testbench

Upstream sequencer for the team's 4-bit mode-controlled rotate register. Generates a programmable "light show" sequence on the register's mode/data/oe inputs:
- load a pattern
- rotate left N steps
- rotate right M steps
- hold K steps
- optionally loop

One rotate or hold step occurs every DIV clocks.

---
 rtl/shift_seq_ctrl_pkg.sv | 44 ++++
 rtl/shift_seq_ctrl_step_tick.sv | 31 +++
 rtl/shift_seq_ctrl.sv | 145 ++++++++++++++
 tb/tb_shift_seq_ctrl.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/shift_seq_ctrl_pkg.sv
// Shared definitions for the light-show sequencer and the downstream rotate register.
// Mode codes match the rotate register's s input.
package shift_seq_ctrl_pkg;

    localparam logic [1:0] MODE_HOLD = 2'b00;
    localparam logic [1:0] MODE_ROTL = 2'b01;
    localparam logic [1:0] MODE_ROTR = 2'b10;
    localparam logic [1:0] MODE_LOAD = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_ROTL = 3'd2,
        ST_ROTR = 3'd3,
        ST_HOLD = 3'd4,
        ST_DONE = 3'd5
    } state_e;

    // Phase that follows cur, skipping zero-count phases; a loop only restarts
    // after at least one phase actually ran.
    function automatic state_e next_phase(input state_e cur, input logic l_nz,
                                          input logic r_nz, input logic h_nz,
                                          input logic lp);
        state_e nxt;
        nxt = lp ? ST_LOAD : ST_DONE;
        case (cur)
            ST_LOAD: nxt = l_nz ? ST_ROTL : r_nz ? ST_ROTR : h_nz ? ST_HOLD : ST_DONE;
            ST_ROTL: begin
                if (r_nz)      nxt = ST_ROTR;
                else if (h_nz) nxt = ST_HOLD;
            end
            ST_ROTR: begin
                if (h_nz) nxt = ST_HOLD;
            end
            default: ;
        endcase
        return nxt;
    endfunction

    function automatic logic is_step(input state_e st);
        return (st == ST_ROTL) || (st == ST_ROTR) || (st == ST_HOLD);
    endfunction

endpackage

// File: rtl/shift_seq_ctrl_step_tick.sv
// DIV-cycle prescaler: cnt runs 0..DIV-1 and restarts from 0 on clr.
// tick_nxt predicts tick one cycle early so the caller can register its outputs.
module step_tick #(
    parameter int DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick,
    output logic tick_nxt
);

    localparam int               CNT_W   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DIV - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        if (clr || cnt_q == CNT_MAX) cnt_d = '0;
        else                         cnt_d = cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    assign tick     = (cnt_q == CNT_MAX);
    assign tick_nxt = (cnt_d == CNT_MAX);

endmodule

// File: rtl/shift_seq_ctrl.sv
// Light-show sequencer driving mode/data/oe of the 4-bit rotate register:
// load, rotate left nl, rotate right nr, hold nh steps, optionally loop.
//
// state | meaning
// IDLE  | waiting for start, oe = OE_IDLE
// LOAD  | one cycle, s=11 with latched pattern
// ROTL  | nl steps, s=01 on each step's last cycle
// ROTR  | nr steps, s=10 on each step's last cycle
// HOLD  | nh steps, s=00 throughout
// DONE  | one cycle done pulse, then IDLE
module shift_seq_ctrl
    import shift_seq_ctrl_pkg::*;
#(
    parameter int DIV     = 4,
    parameter int CW      = 4,
    parameter bit OE_IDLE = 1'b0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          stop,
    input  logic [3:0]    pat,
    input  logic [CW-1:0] nl,
    input  logic [CW-1:0] nr,
    input  logic [CW-1:0] nh,
    input  logic          loop,
    output logic [1:0]    s,
    output logic [3:0]    d,
    output logic          oe,
    output logic          busy,
    output logic          done
);

    state_e        state_q, state_d;
    logic [3:0]    pat_q, pat_d;
    logic [CW-1:0] nl_q, nl_d, nr_q, nr_d, nh_q, nh_d;
    logic          loop_q, loop_d;
    logic [CW-1:0] step_q, step_d;
    logic [CW-1:0] lim;
    logic [1:0]    s_q, s_d;
    logic [3:0]    d_q, d_d;
    logic          oe_q, oe_d, busy_q, busy_d, done_q, done_d;
    logic          clr, tick, tick_nxt, last_step;

    step_tick #(.DIV(DIV)) u_step_tick (
        .clk      (clk),
        .rst      (rst),
        .clr      (clr),
        .tick     (tick),
        .tick_nxt (tick_nxt)
    );

    always_comb begin
        case (state_q)
            ST_ROTL: lim = nl_q;
            ST_ROTR: lim = nr_q;
            ST_HOLD: lim = nh_q;
            default: lim = '0;
        endcase
    end

    assign last_step = tick && (step_q == lim - CW'(1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            pat_q   <= '0;
            nl_q    <= '0;
            nr_q    <= '0;
            nh_q    <= '0;
            loop_q  <= 1'b0;
            step_q  <= '0;
            s_q     <= MODE_HOLD;
            d_q     <= '0;
            oe_q    <= OE_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pat_q   <= pat_d;
            nl_q    <= nl_d;
            nr_q    <= nr_d;
            nh_q    <= nh_d;
            loop_q  <= loop_d;
            step_q  <= step_d;
            s_q     <= s_d;
            d_q     <= d_d;
            oe_q    <= oe_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pat_d   = pat_q;
        nl_d    = nl_q;
        nr_d    = nr_q;
        nh_d    = nh_q;
        loop_d  = loop_q;
        case (state_q)
            ST_IDLE: begin
                if (start && !stop) begin
                    state_d = ST_LOAD;
                    pat_d   = pat;
                    nl_d    = nl;
                    nr_d    = nr;
                    nh_d    = nh;
                    loop_d  = loop;
                end
            end
            ST_LOAD: state_d = next_phase(ST_LOAD, nl_q != '0, nr_q != '0, nh_q != '0, loop_q);
            ST_ROTL, ST_ROTR, ST_HOLD: begin
                if (last_step)
                    state_d = next_phase(state_q, nl_q != '0, nr_q != '0, nh_q != '0, loop_q);
            end
            default: state_d = ST_IDLE;
        endcase
        if (stop && state_q != ST_IDLE) state_d = ST_IDLE;

        clr    = (state_d != state_q) || !is_step(state_d);
        step_d = clr ? '0 : (tick ? step_q + CW'(1) : step_q);
    end

    // Outputs are computed from the next state so they line up with it once registered.
    always_comb begin
        case (state_d)
            ST_LOAD: s_d = MODE_LOAD;
            ST_ROTL: s_d = tick_nxt ? MODE_ROTL : MODE_HOLD;
            ST_ROTR: s_d = tick_nxt ? MODE_ROTR : MODE_HOLD;
            default: s_d = MODE_HOLD;
        endcase
        d_d    = (state_d == ST_LOAD) ? pat_d : d_q;
        oe_d   = (state_d == ST_IDLE) ? OE_IDLE : 1'b0;
        busy_d = (state_d != ST_IDLE);
        done_d = (state_d == ST_DONE);
    end

    assign s    = s_q;
    assign d    = d_q;
    assign oe   = oe_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Bench for shift_seq_ctrl: two builds (DIV=2/OE_IDLE=0, DIV=1/OE_IDLE=1) share stimulus,
// each compared cycle by cycle against a queue of expected outputs built from the sequence rules.
module tb_shift_seq_ctrl;
    import shift_seq_ctrl_pkg::*;

    logic       clk = 1'b0;
    logic       rst, start, stop, loop;
    logic [3:0] pat, nl, nr, nh;
    int         n_checks = 0;
    int         n_fail   = 0;

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : g_dut
        localparam int DIV_G = (g == 0) ? 2 : 1;
        localparam bit OE_G  = (g == 1);

        logic [1:0] s;
        logic [3:0] d;
        logic       oe, busy, done;

        shift_seq_ctrl #(.DIV(DIV_G), .CW(4), .OE_IDLE(OE_G)) dut (
            .clk(clk), .rst(rst), .start(start), .stop(stop), .pat(pat),
            .nl(nl), .nr(nr), .nh(nh), .loop(loop),
            .s(s), .d(d), .oe(oe), .busy(busy), .done(done)
        );

        // Each entry is {s, done} for one busy cycle.
        logic [2:0] q_exp[$];
        logic [2:0] cur      = 3'b000;
        bit         m_busy   = 1'b0;
        logic [3:0] d_exp    = 4'h0;
        logic [3:0] lat_pat  = 4'h0;
        int         lat_n[3] = '{0, 0, 0};
        bit         lat_loop = 1'b0;

        task automatic fill();
            logic [1:0] md[3];
            md[0] = MODE_ROTL;
            md[1] = MODE_ROTR;
            md[2] = MODE_HOLD;
            q_exp.push_back({MODE_LOAD, 1'b0});
            for (int k = 0; k < 3; k++)
                for (int i = 0; i < lat_n[k] * DIV_G; i++)
                    q_exp.push_back({((i % DIV_G) == DIV_G - 1) ? md[k] : MODE_HOLD, 1'b0});
            if (!lat_loop || (lat_n[0] + lat_n[1] + lat_n[2]) == 0)
                q_exp.push_back({MODE_HOLD, 1'b1});
        endtask

        task automatic advance();
            if (q_exp.size() == 0) fill();
            cur = q_exp.pop_front();
            if (cur[2:1] == MODE_LOAD) d_exp = lat_pat;
        endtask

        always begin
            @(posedge clk);
            if (rst) begin
                q_exp.delete();
                m_busy = 1'b0;
                d_exp  = 4'h0;
            end else if (m_busy && stop) begin
                q_exp.delete();
                m_busy = 1'b0;
            end else if (m_busy) begin
                if (q_exp.size() == 0 && cur[0]) m_busy = 1'b0;
                else advance();
            end else if (start && !stop) begin
                lat_pat  = pat;
                lat_n[0] = int'(nl);
                lat_n[1] = int'(nr);
                lat_n[2] = int'(nh);
                lat_loop = loop;
                q_exp.delete();
                m_busy = 1'b1;
                advance();
            end
            #1;
            check_val($sformatf("div%0d s", DIV_G),    32'(s),    m_busy ? 32'(cur[2:1]) : 32'(MODE_HOLD));
            check_val($sformatf("div%0d done", DIV_G), 32'(done), 32'(m_busy && cur[0]));
            check_val($sformatf("div%0d busy", DIV_G), 32'(busy), 32'(m_busy));
            check_val($sformatf("div%0d oe", DIV_G),   32'(oe),   m_busy ? 32'(0) : 32'(OE_G));
            check_val($sformatf("div%0d d", DIV_G),    32'(d),    32'(d_exp));
        end
    end

    task automatic go(input logic [3:0] p, input logic [3:0] l, input logic [3:0] r,
                      input logic [3:0] h, input logic lp);
        @(negedge clk);
        pat = p; nl = l; nr = r; nh = h; loop = lp;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; stop = 1'b0; loop = 1'b0;
        pat = 4'h0; nl = 4'h0; nr = 4'h0; nh = 4'h0;
        idle_cycles(3);
        rst = 1'b0;
        idle_cycles(2);

        // normal sequence, then all-zero counts
        go(4'b0001, 4'd2, 4'd1, 4'd1, 1'b0);
        idle_cycles(14);
        go(4'b1010, 4'd0, 4'd0, 4'd0, 1'b0);
        idle_cycles(4);

        // loop, then stop
        go(4'b1000, 4'd1, 4'd0, 4'd0, 1'b1);
        idle_cycles(9);
        stop = 1'b1;
        idle_cycles(1);
        stop = 1'b0;
        idle_cycles(3);

        // start with stop in IDLE
        @(negedge clk);
        start = 1'b1; stop = 1'b1;
        @(negedge clk);
        start = 1'b0; stop = 1'b0;
        idle_cycles(3);

        // start pulse mid-ROTR and input changes while busy
        go(4'b0110, 4'd1, 4'd3, 4'd1, 1'b0);
        idle_cycles(3);
        pat = 4'b1111; nl = 4'd7; start = 1'b1;
        idle_cycles(1);
        start = 1'b0;
        idle_cycles(12);

        // reset mid-HOLD, then a fresh run
        go(4'b0011, 4'd1, 4'd0, 4'd4, 1'b0);
        idle_cycles(5);
        rst = 1'b1;
        idle_cycles(1);
        rst = 1'b0;
        idle_cycles(2);
        go(4'b0101, 4'd1, 4'd2, 4'd1, 1'b0);
        idle_cycles(14);

        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            start = ($urandom_range(0, 7) == 0);
            stop  = ($urandom_range(0, 59) == 0);
            rst   = ($urandom_range(0, 249) == 0);
            loop  = ($urandom_range(0, 4) == 0);
            pat   = 4'($urandom);
            nl    = ($urandom_range(0, 9) == 0) ? 4'($urandom) : 4'($urandom_range(0, 3));
            nr    = ($urandom_range(0, 9) == 0) ? 4'($urandom) : 4'($urandom_range(0, 3));
            nh    = ($urandom_range(0, 9) == 0) ? 4'($urandom) : 4'($urandom_range(0, 3));
        end
        start = 1'b0; stop = 1'b0; rst = 1'b0;
        idle_cycles(2);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
